// File: rtl/spi_frame_pkg.sv
// Shared constants for the framed SPI slave: FSM state codes and command encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_frame_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RX      = 3'd1;
  localparam state_t ST_WAIT_TX = 3'd2;
  localparam state_t ST_TX      = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-to-serial shifter for read data returned on MISO.
// Latency: first bit valid the cycle after load; one bit per shift; serial_out returns to 0 on the shift after the last bit.
// Backpressure: none; the caller asserts shift every cycle it wants the next bit.
// Ports: clk, rst (sync, active-high), load/load_data (capture word, drive first bit),
//        shift (advance one bit), clear (discard word, force 0), serial_out, done (this shift ends the word).
module spi_tx_shifter #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              serial_out,
  output logic              done
);

  localparam int                CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              first_bit;
  logic              next_bit;
  logic [DATA_W-1:0] load_rest;
  logic [DATA_W-1:0] shift_rest;

  always_comb begin
    if (LSB_FIRST != 0) begin
      first_bit  = load_data[0];
      load_rest  = load_data >> 1;
      next_bit   = sh_q[0];
      shift_rest = sh_q >> 1;
    end else begin
      first_bit  = load_data[DATA_W-1];
      load_rest  = load_data << 1;
      next_bit   = sh_q[DATA_W-1];
      shift_rest = sh_q << 1;
    end
  end

  // cnt_q counts bits already placed on serial_out; once all DATA_W have
  // been shown for a cycle, the next shift drops the line back to 0.
  assign done = shift && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      serial_out <= 1'b0;
    end else if (load) begin
      serial_out <= first_bit;
      sh_q       <= load_rest;
      cnt_q      <= CNT_W'(1);
    end else if (shift) begin
      if (cnt_q == LAST) begin
        serial_out <= 1'b0;
        cnt_q      <= '0;
      end else begin
        serial_out <= next_bit;
        sh_q       <= shift_rest;
        cnt_q      <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave_frame.sv
// Framed SPI slave: deserialises {cmd, payload} from MOSI, strobes it to the RAM, returns read data on MISO.
// Latency: rx_valid/frame_err registered on the edge sampling the last frame bit; MISO first bit the cycle after tx_valid is seen.
// Backpressure: none toward the master; waits up to TX_TIMEOUT cycles for tx_valid (0 = forever), SS_n high aborts.
// Ports: clk, rst (sync, active-high), SS_n, MOSI, tx_data/tx_valid (read data from RAM),
//        rx_data ({cmd, payload}), rx_valid (frame strobe), MISO, frame_err (error strobe).
module spi_slave_frame
  import spi_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 0,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              frame_err
);

  localparam int                FRAME_W  = DATA_W + 2;
  localparam int                CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam int                TO_W     = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = (TX_TIMEOUT > 0) ? TO_W'(TX_TIMEOUT - 1) : '0;

  state_t            state;
  logic [CNT_W-1:0]  cnt_q;
  logic [TO_W-1:0]   tcnt_q;
  logic [1:0]        cmd_q;
  logic [DATA_W-1:0] pay_q;
  logic [DATA_W-1:0] pay_next;
  logic              rd_addr_seen;
  logic              tx_load;
  logic              tx_shift;
  logic              tx_clear;
  logic              tx_done;

  // The command is always MSB-first; only the payload honours LSB_FIRST.
  always_comb begin
    if (LSB_FIRST != 0) begin
      pay_next = {MOSI, pay_q[DATA_W-1:1]};
    end else begin
      pay_next = {pay_q[DATA_W-2:0], MOSI};
    end
  end

  assign tx_load  = (state == ST_WAIT_TX) && !SS_n && tx_valid;
  assign tx_shift = (state == ST_TX) && !SS_n;
  assign tx_clear = SS_n && ((state == ST_WAIT_TX) || (state == ST_TX));

  spi_tx_shifter #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (tx_load),
    .shift      (tx_shift),
    .clear      (tx_clear),
    .load_data  (tx_data),
    .serial_out (MISO),
    .done       (tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      cmd_q        <= '0;
      pay_q        <= '0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!SS_n) begin
            state <= ST_RX;
            cnt_q <= '0;
          end
        end

        ST_RX: begin
          if (SS_n) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else begin
            if (cnt_q < CNT_W'(2)) begin
              cmd_q <= {cmd_q[0], MOSI};
            end else begin
              pay_q <= pay_next;
            end
            if (cnt_q == CNT_LAST) begin
              // cmd_q is complete here since the command precedes >= 1 payload bit.
              rx_data <= {cmd_q, pay_next};
              case (cmd_q)
                CMD_RD_ADDR: begin
                  rx_valid     <= 1'b1;
                  rd_addr_seen <= 1'b1;
                  state        <= ST_DONE;
                end
                CMD_RD_DATA: begin
                  if (rd_addr_seen) begin
                    rx_valid     <= 1'b1;
                    rd_addr_seen <= 1'b0;
                    tcnt_q       <= '0;
                    state        <= ST_WAIT_TX;
                  end else begin
                    frame_err <= 1'b1;
                    state     <= ST_DONE;
                  end
                end
                default: begin
                  rx_valid <= 1'b1;
                  state    <= ST_DONE;
                end
              endcase
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        ST_WAIT_TX: begin
          if (SS_n) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (tx_valid) begin
            state <= ST_TX;
          end else if ((TX_TIMEOUT > 0) && (tcnt_q == TO_LAST)) begin
            frame_err <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tcnt_q <= tcnt_q + TO_W'(1);
          end
        end

        ST_TX: begin
          if (SS_n) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (tx_done) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (SS_n) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: 8-bit MSB-first (timeout 4) and 12-bit LSB-first instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: DATA_W=8, MSB-first, TX_TIMEOUT=4
  logic        a_rst = 1'b1, a_ss_n = 1'b1, a_mosi = 1'b0, a_tx_valid = 1'b0;
  logic [7:0]  a_tx_data = '0;
  logic [9:0]  a_rx_data;
  logic        a_rx_valid, a_miso, a_frame_err;

  // Instance B: DATA_W=12, LSB-first, TX_TIMEOUT=16
  logic        b_rst = 1'b1, b_ss_n = 1'b1, b_mosi = 1'b0, b_tx_valid = 1'b0;
  logic [11:0] b_tx_data = '0;
  logic [13:0] b_rx_data;
  logic        b_rx_valid, b_miso, b_frame_err;

  spi_slave_frame #(.DATA_W(8), .LSB_FIRST(0), .TX_TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst(a_rst), .SS_n(a_ss_n), .MOSI(a_mosi),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .MISO(a_miso), .frame_err(a_frame_err)
  );

  spi_slave_frame #(.DATA_W(12), .LSB_FIRST(1), .TX_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .SS_n(b_ss_n), .MOSI(b_mosi),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .MISO(b_miso), .frame_err(b_frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   a_early_v, a_early_e, b_early_v;
  logic a_miso_seen;

  // Select, then shift frame MSB-first; SS_n stays low after the last bit.
  task automatic a_send(input logic [9:0] f);
    a_early_v = 0; a_early_e = 0; a_miso_seen = 1'b0;
    a_ss_n = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      a_mosi = f[9-i];
      tick();
      if (i < 9) begin
        a_early_v += int'(a_rx_valid);
        a_early_e += int'(a_frame_err);
      end
      a_miso_seen |= a_miso;
    end
  endtask

  task automatic a_release();
    a_ss_n = 1'b1;
    a_mosi = 1'b0;
    tick();
  endtask

  // Command bits go out MSB-first, payload LSB-first.
  task automatic b_send(input logic [1:0] cmd, input logic [11:0] pay);
    b_early_v = 0;
    b_ss_n = 1'b0;
    tick();
    b_mosi = cmd[1]; tick(); b_early_v += int'(b_rx_valid);
    b_mosi = cmd[0]; tick(); b_early_v += int'(b_rx_valid);
    for (int k = 0; k < 12; k++) begin
      b_mosi = pay[k];
      tick();
      if (k < 11) b_early_v += int'(b_rx_valid);
    end
  endtask

  task automatic b_release();
    b_ss_n = 1'b1;
    b_mosi = 1'b0;
    tick();
  endtask

  logic [7:0]  a_exp_tx;
  logic [11:0] b_exp_tx;

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    check("a_rst_rx_data", a_rx_data, 10'h000);
    check("a_rst_rx_valid", a_rx_valid, 1'b0);
    check("a_rst_miso", a_miso, 1'b0);
    check("a_rst_frame_err", a_frame_err, 1'b0);
    check("b_rst_rx_data", b_rx_data, 14'h0000);

    // ---------------- A: read data without prior read address ----------------
    a_send(10'b11_00000000);
    check("a_seqerr_early_err", a_early_e, 0);
    check("a_seqerr_rx_valid", a_rx_valid, 1'b0);
    check("a_seqerr_frame_err", a_frame_err, 1'b1);
    a_release();
    check("a_seqerr_err_one_cycle", a_frame_err, 1'b0);

    // ---------------- A: write address ----------------
    a_send(10'b00_10100101);
    check("a_wa_early_valid", a_early_v, 0);
    check("a_wa_rx_valid", a_rx_valid, 1'b1);
    check("a_wa_rx_data", a_rx_data, 10'h0A5);
    check("a_wa_frame_err", a_frame_err, 1'b0);
    check("a_wa_miso_quiet", a_miso_seen, 1'b0);
    a_release();
    check("a_wa_valid_one_cycle", a_rx_valid, 1'b0);

    // ---------------- A: read address then read data ----------------
    a_send(10'b10_00001111);
    check("a_ra_rx_valid", a_rx_valid, 1'b1);
    check("a_ra_rx_data", a_rx_data, 10'h20F);
    a_release();
    a_send(10'b11_10101010);
    check("a_rd_rx_valid", a_rx_valid, 1'b1);
    check("a_rd_rx_data", a_rx_data, 10'h3AA);
    tick();
    check("a_rd_wait_miso", a_miso, 1'b0);
    a_tx_valid = 1'b1;
    a_tx_data  = 8'h3C;
    tick();
    a_tx_valid = 1'b0;
    a_exp_tx = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a_rd_miso_bit%0d", i), a_miso, a_exp_tx[7-i]);
      check($sformatf("a_rd_no_err%0d", i), a_frame_err, 1'b0);
      tick();
    end
    check("a_rd_miso_after", a_miso, 1'b0);
    a_release();

    // ---------------- A: abort after 5 bits ----------------
    a_ss_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      a_mosi = (i == 2) ? 1'b1 : 1'b0;
      tick();
    end
    a_ss_n = 1'b1;
    tick();
    check("a_abort_frame_err", a_frame_err, 1'b1);
    check("a_abort_rx_valid", a_rx_valid, 1'b0);
    check("a_abort_rx_data_held", a_rx_data, 10'h3AA);
    tick();
    check("a_abort_err_one_cycle", a_frame_err, 1'b0);
    a_send(10'b01_11110000);
    check("a_post_abort_rx_valid", a_rx_valid, 1'b1);
    check("a_post_abort_rx_data", a_rx_data, 10'h1F0);
    a_release();

    // ---------------- A: tx_valid timeout ----------------
    a_send(10'b10_00000001);
    a_release();
    a_send(10'b11_00000000);
    check("a_to_rx_valid", a_rx_valid, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("a_to_err_edge%0d", k), a_frame_err, (k == 4) ? 1'b1 : 1'b0);
      check($sformatf("a_to_miso_edge%0d", k), a_miso, 1'b0);
    end
    a_release();

    // ---------------- B: LSB-first write data ----------------
    b_send(2'b01, 12'hABC);
    check("b_wd_early_valid", b_early_v, 0);
    check("b_wd_rx_valid", b_rx_valid, 1'b1);
    check("b_wd_rx_data", b_rx_data, 14'h1ABC);
    b_release();

    // ---------------- B: read sequence, full word ----------------
    b_send(2'b10, 12'h005);
    check("b_ra_rx_data", b_rx_data, 14'h2005);
    b_release();
    b_send(2'b11, 12'h000);
    check("b_rd_rx_valid", b_rx_valid, 1'b1);
    b_tx_valid = 1'b1;
    b_tx_data  = 12'h801;
    tick();
    b_tx_valid = 1'b0;
    b_exp_tx = 12'h801;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("b_rd_miso_bit%0d", i), b_miso, b_exp_tx[i]);
      tick();
    end
    check("b_rd_miso_after", b_miso, 1'b0);
    check("b_rd_no_err", b_frame_err, 1'b0);
    b_release();

    // ---------------- B: reset in the middle of TX ----------------
    b_send(2'b10, 12'h001);
    b_release();
    b_send(2'b11, 12'h000);
    b_tx_valid = 1'b1;
    b_tx_data  = 12'h801;
    tick();
    b_tx_valid = 1'b0;
    check("b_mid_miso_bit0", b_miso, 1'b1);
    tick(); tick();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    check("b_mid_rst_miso", b_miso, 1'b0);
    check("b_mid_rst_rx_data", b_rx_data, 14'h0000);
    check("b_mid_rst_frame_err", b_frame_err, 1'b0);
    b_release();
    // Reset also forgets the pending read address.
    b_send(2'b11, 12'h000);
    check("b_post_rst_seq_err", b_frame_err, 1'b1);
    check("b_post_rst_rx_valid", b_rx_valid, 1'b0);
    b_release();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
